colour_classifier: RTL and testbench

COLOUR_CLASSIFIER -- requirements
Module: colour_classifier

---
 rtl/colour_classifier.sv | 186 ++++++++++++++++++
 tb/tb_colour_classifier.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/colour_classifier.sv
// Colour sensor front end: cycles the sensor filter through RED/BLUE/CLEAR/GREEN,
// counts synchronised frequency edges per window, publishes per-frame counts and
// drives debounced (confirmed) colour LEDs.
module colour_classifier #(
    parameter int unsigned WINDOW_CYCLES = 78125,
    parameter int unsigned SETTLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned CLEAR_MIN     = 200,
    parameter int unsigned CONFIRM       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             colour_freq,
    output logic             s2,
    output logic             s3,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] clear_cnt,
    output logic             frame_valid,
    output logic             red_led,
    output logic             green_led,
    output logic             blue_led
);

    localparam int unsigned     WIN_W      = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_SETTLE = WIN_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [3:0]       CONF_TGT   = 4'(CONFIRM);

    typedef enum logic [1:0] {
        CH_RED   = 2'b00,
        CH_BLUE  = 2'b01,
        CH_CLEAR = 2'b10,
        CH_GREEN = 2'b11
    } chan_t;

    typedef enum logic [1:0] {
        DEC_NONE  = 2'd0,
        DEC_RED   = 2'd1,
        DEC_GREEN = 2'd2,
        DEC_BLUE  = 2'd3
    } dec_t;

    logic             sync_q1, sync_q2;
    logic             edge_det;
    logic [WIN_W-1:0] win_cnt;
    logic             win_last;
    logic             count_en;
    logic [CNT_W-1:0] edge_cnt, cnt_next;
    chan_t            chan_q, chan_d;
    logic [CNT_W-1:0] sh_red, sh_green, sh_blue, sh_clear;
    logic             frame_pend;
    dec_t             dec, prev_dec;
    logic [3:0]       conf_q, conf_nxt;

    // Two-flop synchroniser for the asynchronous sensor output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= colour_freq;
            sync_q2 <= sync_q1;
        end
    end

    // Edge detect, settle gating and saturating increment (includes final-cycle edge)
    always_comb begin
        edge_det = sync_q1 & ~sync_q2;
        win_last = (win_cnt == WIN_LAST);
        count_en = (win_cnt >= WIN_SETTLE);
        cnt_next = edge_cnt;
        if (edge_det && count_en && (edge_cnt != CNT_MAX)) begin
            cnt_next = edge_cnt + CNT_W'(1);
        end
    end

    // Window timer and per-window edge counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (win_last) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= cnt_next;
        end
    end

    // Filter channel state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chan_q <= CH_RED;
        else        chan_q <= chan_d;
    end

    // Filter channel sequencing, advancing at each window end
    always_comb begin
        chan_d = chan_q;
        if (win_last) begin
            unique case (chan_q)
                CH_RED:   chan_d = CH_BLUE;
                CH_BLUE:  chan_d = CH_CLEAR;
                CH_CLEAR: chan_d = CH_GREEN;
                CH_GREEN: chan_d = CH_RED;
            endcase
        end
    end

    assign s2 = chan_q[1];
    assign s3 = chan_q[0];

    // Latch the finished window into the shadow of the active channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_red     <= '0;
            sh_green   <= '0;
            sh_blue    <= '0;
            sh_clear   <= '0;
            frame_pend <= 1'b0;
        end else begin
            frame_pend <= win_last && (chan_q == CH_GREEN);
            if (win_last) begin
                unique case (chan_q)
                    CH_RED:   sh_red   <= cnt_next;
                    CH_BLUE:  sh_blue  <= cnt_next;
                    CH_CLEAR: sh_clear <= cnt_next;
                    CH_GREEN: sh_green <= cnt_next;
                endcase
            end
        end
    end

    // Frame decision from the shadows; ties favour red, then green
    always_comb begin
        dec = DEC_NONE;
        if (32'(sh_clear) >= CLEAR_MIN) begin
            if (sh_red >= sh_green && sh_red >= sh_blue) dec = DEC_RED;
            else if (sh_green >= sh_blue)                dec = DEC_GREEN;
            else                                         dec = DEC_BLUE;
        end
    end

    // Saturating run length of identical decisions
    always_comb begin
        conf_nxt = 4'd1;
        if (dec == prev_dec) begin
            conf_nxt = (conf_q >= CONF_TGT) ? CONF_TGT : conf_q + 4'd1;
        end
    end

    // Publish counts, pulse frame_valid and update confirmed LEDs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_cnt     <= '0;
            green_cnt   <= '0;
            blue_cnt    <= '0;
            clear_cnt   <= '0;
            frame_valid <= 1'b0;
            red_led     <= 1'b0;
            green_led   <= 1'b0;
            blue_led    <= 1'b0;
            conf_q      <= 4'd0;
            prev_dec    <= DEC_NONE;
        end else begin
            frame_valid <= frame_pend;
            if (frame_pend) begin
                red_cnt   <= sh_red;
                green_cnt <= sh_green;
                blue_cnt  <= sh_blue;
                clear_cnt <= sh_clear;
                conf_q    <= conf_nxt;
                prev_dec  <= dec;
                if (conf_nxt == CONF_TGT) begin
                    red_led   <= (dec == DEC_RED);
                    green_led <= (dec == DEC_GREEN);
                    blue_led  <= (dec == DEC_BLUE);
                end
            end
        end
    end

endmodule

// File: tb/tb_colour_classifier.sv
// Bench for colour_classifier: drives per-window edge patterns and checks counts,
// frame timing, channel selects and confirmed LEDs against a frame-level model.
module tb_colour_classifier;

    localparam int WIN    = 100;
    localparam int SETTLE = 10;
    localparam int CMIN   = 5;
    localparam int CONF   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic colour_freq;

    logic       s2, s3, frame_valid, red_led, green_led, blue_led;
    logic [7:0] red_cnt, green_cnt, blue_cnt, clear_cnt;

    logic       t_s2, t_s3, t_fv, t_rl, t_gl, t_bl;
    logic [3:0] t_r, t_g, t_b, t_c;

    colour_classifier #(
        .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SETTLE), .CNT_W(8),
        .CLEAR_MIN(CMIN), .CONFIRM(CONF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .colour_freq(colour_freq),
        .s2(s2), .s3(s3),
        .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt), .clear_cnt(clear_cnt),
        .frame_valid(frame_valid),
        .red_led(red_led), .green_led(green_led), .blue_led(blue_led)
    );

    // Narrow-counter, CONFIRM=1 instance sharing the same stimulus
    colour_classifier #(
        .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SETTLE), .CNT_W(4),
        .CLEAR_MIN(CMIN), .CONFIRM(1)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .colour_freq(colour_freq),
        .s2(t_s2), .s3(t_s3),
        .red_cnt(t_r), .green_cnt(t_g), .blue_cnt(t_b), .clear_cnt(t_c),
        .frame_valid(t_fv),
        .red_led(t_rl), .green_led(t_gl), .blue_led(t_bl)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Frame-level reference model state
    bit       pend;
    int       e_r, e_g, e_b, e_c;
    logic [2:0] e_led, e_led_sat;
    int       prev_dec, conf;

    function automatic int decide(input int r, input int g, input int b, input int c);
        if (c < CMIN) return 0;
        if (r >= g && r >= b) return 1;
        if (g >= b) return 2;
        return 3;
    endfunction

    function automatic logic [2:0] led_of(input int d);
        case (d)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int satv(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    // Assert reset, check outputs immediately and after clocks, release on a falling edge
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({s2, s3, red_cnt, green_cnt, blue_cnt, clear_cnt, frame_valid, red_led, green_led, blue_led} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h required 0", {s2, s3, red_cnt, green_cnt, blue_cnt, clear_cnt, frame_valid, red_led, green_led, blue_led});
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({s2, s3, red_cnt, green_cnt, blue_cnt, clear_cnt, frame_valid, red_led, green_led, blue_led} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h required 0", {s2, s3, red_cnt, green_cnt, blue_cnt, clear_cnt, frame_valid, red_led, green_led, blue_led});
        end
        vectors++;
        if ({t_s2, t_s3, t_r, t_g, t_b, t_c, t_fv, t_rl, t_gl, t_bl} !== '0) begin
            errors++;
            $display("FAIL reset_sat: outputs=%h required 0", {t_s2, t_s3, t_r, t_g, t_b, t_c, t_fv, t_rl, t_gl, t_bl});
        end
        colour_freq = 1'b0;
        pend      = 1'b0;
        prev_dec  = 0;
        conf      = 0;
        e_led     = 3'b000;
        e_led_sat = 3'b000;
        rst_n     = 1'b1;
    endtask

    // Drive one frame (R,B,C,G windows); post-settle edges end at the last window cycle
    task automatic run_frame(input int n_r, input int n_b, input int n_c, input int n_g,
                             input int pre, input int ncycles);
        logic lvl [0:399];
        int   n_win [4];
        int   cnt [4];
        int   d;
        n_win = '{n_r, n_b, n_c, n_g};
        for (int i = 0; i < 400; i++) lvl[i] = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < pre; k++)      lvl[w*WIN + 8 - 2*k]  = 1'b1;
            for (int k = 0; k < n_win[w]; k++) lvl[w*WIN + 98 - 2*k] = 1'b1;
        end
        for (int c = 0; c < ncycles; c++) begin
            colour_freq = lvl[c];
            vectors++;
            if (frame_valid !== ((c == 1) && pend)) begin
                errors++;
                $display("FAIL frame_valid at cycle %0d: got %b required %b", c, frame_valid, (c == 1) && pend);
            end
            if (c == 1 && pend) begin
                vectors++;
                if ({red_cnt, blue_cnt, clear_cnt, green_cnt} !== {8'(e_r), 8'(e_b), 8'(e_c), 8'(e_g)}) begin
                    errors++;
                    $display("FAIL counts: r/b/c/g got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                             red_cnt, blue_cnt, clear_cnt, green_cnt, e_r, e_b, e_c, e_g);
                end
                vectors++;
                if ({red_led, green_led, blue_led} !== e_led) begin
                    errors++;
                    $display("FAIL leds: got %b required %b", {red_led, green_led, blue_led}, e_led);
                end
                vectors++;
                if ({t_r, t_b, t_c, t_g} !== {4'(satv(e_r, 15)), 4'(satv(e_b, 15)), 4'(satv(e_c, 15)), 4'(satv(e_g, 15))}) begin
                    errors++;
                    $display("FAIL sat_counts: r/b/c/g got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                             t_r, t_b, t_c, t_g, satv(e_r, 15), satv(e_b, 15), satv(e_c, 15), satv(e_g, 15));
                end
                vectors++;
                if ({t_rl, t_gl, t_bl} !== e_led_sat) begin
                    errors++;
                    $display("FAIL sat_leds: got %b required %b", {t_rl, t_gl, t_bl}, e_led_sat);
                end
                pend = 1'b0;
            end
            if (c % WIN == 50) begin
                vectors++;
                if ({s2, s3} !== 2'(c / WIN)) begin
                    errors++;
                    $display("FAIL filter_select at cycle %0d: got %b required %b", c, {s2, s3}, 2'(c / WIN));
                end
            end
            @(negedge clk);
        end
        if (ncycles == 400) begin
            // A rising level at cycle c is seen by the counter in cycle c+1
            for (int w = 0; w < 4; w++) begin
                cnt[w] = 0;
                for (int c = 1; c < WIN; c++) begin
                    if (lvl[w*WIN + c] && !lvl[w*WIN + c - 1] && (c + 1) >= SETTLE && (c + 1) <= WIN - 1)
                        cnt[w]++;
                end
            end
            e_r = cnt[0]; e_b = cnt[1]; e_c = cnt[2]; e_g = cnt[3];
            d = decide(e_r, e_g, e_b, e_c);
            if (d == prev_dec) conf = (conf + 1 > CONF) ? CONF : conf + 1;
            else               conf = 1;
            prev_dec = d;
            if (conf == CONF) e_led = led_of(d);
            e_led_sat = led_of(decide(satv(e_r, 15), satv(e_g, 15), satv(e_b, 15), satv(e_c, 15)));
            pend = 1'b1;
        end
    endtask

    task automatic flush();
        run_frame(0, 0, 0, 0, 0, 2);
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_nominal();
        apply_reset();
        repeat (3) run_frame(30, 10, 40, 12, 0, 400);
        flush();
    endtask

    task automatic test_settle();
        apply_reset();
        repeat (2) run_frame(5, 5, 5, 5, 3, 400);
        flush();
    endtask

    task automatic test_saturation();
        apply_reset();
        run_frame(40, 10, 30, 20, 0, 400);
        run_frame(44, 16, 44, 3, 0, 400);
        flush();
    endtask

    task automatic test_no_object();
        apply_reset();
        repeat (2) run_frame(30, 10, 40, 12, 0, 400);
        repeat (2) run_frame(20, 20, 4, 20, 0, 400);
        flush();
    endtask

    task automatic test_tie_alternate();
        apply_reset();
        repeat (2) run_frame(20, 10, 50, 20, 0, 400);
        for (int i = 0; i < 2; i++) begin
            run_frame(5, 30, 40, 5, 0, 400);
            run_frame(30, 5, 40, 5, 0, 400);
        end
    endtask

    task automatic test_reset_mid();
        run_frame(25, 5, 40, 5, 0, 150);
        apply_reset();
        run_frame(12, 30, 40, 25, 0, 400);
        run_frame(12, 30, 40, 25, 0, 400);
        flush();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(0, 44)), int'($urandom_range(0, 44)),
                      int'($urandom_range(0, 12)), int'($urandom_range(0, 44)),
                      int'($urandom_range(0, 3)), 400);
        end
        flush();
    endtask

    initial begin
        rst_n       = 1'b1;
        colour_freq = 1'b0;
        #3;
        test_reset();
        test_nominal();
        test_settle();
        test_saturation();
        test_no_object();
        test_tie_alternate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
